// File: rtl/sblk_pkg.sv
// sblk_pkg: shared instruction field widths, scheduler state and instruction type
package sblk_pkg;

    localparam int WID_INST_TN = 3;
    localparam int WID_INST_TM = 3;
    localparam int WID_INST_TP = 2;
    localparam int WID_INST_LN = 3;
    localparam int WID_INST_LP = 3;
    localparam int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP + WID_INST_LN + WID_INST_LP;

    typedef enum logic {IDLE, ISSUE} sched_state_e;

    typedef struct packed {
        logic [WID_INST_TN-1:0] tn;
        logic [WID_INST_TM-1:0] tm;
        logic [WID_INST_TP-1:0] tp;
        logic [WID_INST_LN-1:0] ln;
        logic [WID_INST_LP-1:0] lp;
    } inst_t;

endpackage

// File: rtl/sblk_row_tracker.sv
// sblk_row_tracker: per-row start-pending window with start timeout detection
module sblk_row_tracker #(
    parameter int START_TIMEOUT = 15
) (
    input  logic clk_l,
    input  logic rst,
    input  logic issue_i,
    input  logic status_i,
    output logic pending_o,
    output logic timeout_o
);

    localparam int CW = $clog2(START_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          pending_q;
    logic          timeout_q;
    logic          waiting;
    logic          expire;

    // The issue cycle itself counts as the first waiting cycle, so expiry lands
    // exactly START_TIMEOUT cycles after the strobe.
    assign waiting   = pending_q & ~status_i;
    assign expire    = waiting & (cnt_q == CW'(START_TIMEOUT - 1));
    assign pending_o = pending_q;
    assign timeout_o = timeout_q;

    // Pending window: armed by issue, dropped once busy is seen or the window expires
    always_ff @(posedge clk_l) begin
        if (rst) begin
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= issue_i ? ~status_i : waiting & ~expire;
            timeout_q <= ~issue_i & expire;
            cnt_q     <= issue_i ? CW'(1) : (waiting & ~expire) ? cnt_q + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/sblk_row_sched.sv
// sblk_row_sched: masked instruction broadcast scheduler for a row of superblocks
module sblk_row_sched
    import sblk_pkg::*;
#(
    parameter int N_ROW         = 30,
    parameter int WID_INST      = sblk_pkg::WID_INST,
    parameter int START_TIMEOUT = 15,
    parameter int WID_CNT       = 16
) (
    input  logic                      clk_l,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [WID_INST-1:0]       cmd_inst,
    input  logic [N_ROW-1:0]          cmd_row_mask,
    input  logic                      cmd_barrier,
    input  logic                      drain_req,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    output logic [N_ROW-1:0]          row_busy,
    output logic                      sched_idle,
    output logic                      err_timeout,
    output logic                      err_empty,
    output logic [WID_CNT-1:0]        issued_cnt
);

    sched_state_e     state_q;
    logic [N_ROW-1:0] pending;
    logic [N_ROW-1:0] timeout;
    logic             accept;

    assign row_busy    = pending | status_sblk;
    assign cmd_ready   = ~rst & (state_q == IDLE) & ~drain_req &
                         (cmd_barrier ? ~|row_busy : ~|(cmd_row_mask & row_busy));
    assign sched_idle  = ~rst & (state_q == IDLE) & ~|row_busy;
    assign err_timeout = |timeout;
    assign accept      = cmd_valid & cmd_ready;

    for (genvar g = 0; g < N_ROW; g++) begin : g_row
        sblk_row_tracker #(
            .START_TIMEOUT(START_TIMEOUT)
        ) u_trk (
            .clk_l    (clk_l),
            .rst      (rst),
            .issue_i  (inst_en[g]),
            .status_i (status_sblk[g]),
            .pending_o(pending[g]),
            .timeout_o(timeout[g])
        );
    end

    // Accept/issue FSM; the latched mask doubles as the one-cycle issue strobe
    always_ff @(posedge clk_l) begin
        if (rst) begin
            state_q    <= IDLE;
            inst_en    <= '0;
            err_empty  <= 1'b0;
            issued_cnt <= '0;
            inst_data  <= '0;
        end else begin
            state_q   <= accept ? ISSUE : IDLE;
            inst_en   <= accept ? cmd_row_mask : '0;
            err_empty <= accept & ~|cmd_row_mask;
            if (accept && |cmd_row_mask)
                issued_cnt <= issued_cnt + 1'b1;
            for (int i = 0; i < N_ROW; i++)
                if (accept && cmd_row_mask[i])
                    inst_data[i*WID_INST +: WID_INST] <= cmd_inst;
        end
    end

endmodule

// File: tb/tb_sblk_row_sched.sv
// tb_sblk_row_sched: directed and randomized checks against a history-based model
module tb_sblk_row_sched;

    localparam int N  = 30;
    localparam int W  = 14;
    localparam int TO = 15;

    logic           clk_l = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [W-1:0]   cmd_inst;
    logic [N-1:0]   cmd_row_mask;
    logic           cmd_barrier;
    logic           drain_req;
    logic [N-1:0]   status_sblk;
    logic [W*N-1:0] inst_data;
    logic [N-1:0]   inst_en;
    logic [N-1:0]   row_busy;
    logic           sched_idle;
    logic           err_timeout;
    logic           err_empty;
    logic [15:0]    issued_cnt;

    sblk_row_sched #(
        .N_ROW(N), .WID_INST(W), .START_TIMEOUT(TO), .WID_CNT(16)
    ) dut (
        .clk_l(clk_l), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_inst(cmd_inst), .cmd_row_mask(cmd_row_mask), .cmd_barrier(cmd_barrier),
        .drain_req(drain_req), .status_sblk(status_sblk), .inst_data(inst_data),
        .inst_en(inst_en), .row_busy(row_busy), .sched_idle(sched_idle),
        .err_timeout(err_timeout), .err_empty(err_empty), .issued_cnt(issued_cnt)
    );

    always #5 clk_l = ~clk_l;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each row remembers when it was last strobed and whether status has been
    // seen since; pending/timeout follow from elapsed cycles.
    int             cyc       = 0;
    bit             rst_prev  = 1'b0;
    bit             acc_prev  = 1'b0;
    logic [N-1:0]   mask_prev = '0;
    int             iss[N];
    bit             clean[N];
    logic [W*N-1:0] mdata     = '0;
    int             mcnt      = 0;

    always @(negedge clk_l) begin : model
        logic [N-1:0] pend;
        logic [N-1:0] busy;
        logic [N-1:0] en_exp;
        logic         to_exp;
        logic         rdy_exp;
        logic         acc;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_en", inst_en, 0);
                chk("rst_ready", cmd_ready, 0);
                chk("rst_idle", sched_idle, 0);
                chk("rst_err", {err_timeout, err_empty}, 0);
                chk("rst_cnt", issued_cnt, 0);
                chk("rst_data", inst_data, 0);
                chk("rst_busy", row_busy, status_sblk);
            end
            acc_prev  = 1'b0;
            mask_prev = '0;
            mdata     = '0;
            mcnt      = 0;
            for (int i = 0; i < N; i++) begin
                iss[i]   = -1;
                clean[i] = 1'b0;
            end
        end else begin
            pend   = '0;
            to_exp = 1'b0;
            for (int i = 0; i < N; i++)
                if (iss[i] >= 0 && clean[i]) begin
                    if (cyc > iss[i] && cyc - iss[i] < TO) pend[i] = 1'b1;
                    if (cyc - iss[i] == TO) to_exp = 1'b1;
                end
            busy    = pend | status_sblk;
            en_exp  = acc_prev ? mask_prev : '0;
            rdy_exp = !acc_prev && !drain_req &&
                      (cmd_barrier ? busy == '0 : (cmd_row_mask & busy) == '0);
            chk("m_busy", row_busy, busy);
            chk("m_ready", cmd_ready, rdy_exp);
            chk("m_en", inst_en, en_exp);
            chk("m_idle", sched_idle, !acc_prev && busy == '0);
            chk("m_err_timeout", err_timeout, to_exp);
            chk("m_err_empty", err_empty, acc_prev && mask_prev == '0);
            chk("m_cnt", issued_cnt, 16'(mcnt));
            chk("m_data", inst_data, mdata);
            acc = cmd_valid && rdy_exp;
            for (int i = 0; i < N; i++)
                if (en_exp[i]) begin
                    iss[i]   = cyc;
                    clean[i] = !status_sblk[i];
                end else begin
                    clean[i] = clean[i] && !status_sblk[i];
                end
            if (acc) begin
                for (int i = 0; i < N; i++)
                    if (cmd_row_mask[i]) mdata[i*W +: W] = cmd_inst;
                if (cmd_row_mask != '0) mcnt++;
            end
            acc_prev  = acc;
            mask_prev = cmd_row_mask;
        end
        rst_prev = rst;
        cyc++;
    end

    task automatic next();
        @(posedge clk_l);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk_l);
            if (sched_idle) break;
            next();
        end
        chk(name, sched_idle, 1);
        next();
    endtask

    initial begin
        int k;
        rst = 1'b1; cmd_valid = 1'b0; cmd_inst = '0; cmd_row_mask = '0;
        cmd_barrier = 1'b0; drain_req = 1'b0; status_sblk = '0;
        next();
        repeat (2) begin
            @(negedge clk_l);
            chk("reset_en", inst_en, 0);
            chk("reset_idle", sched_idle, 0);
            next();
        end
        rst = 1'b0;
        @(negedge clk_l);
        chk("idle_after_reset", sched_idle, 1);
        next();
        // basic issue to rows 0 and 2, left to time out
        cmd_valid = 1'b1; cmd_row_mask = 30'h5; cmd_inst = 14'h1A5;
        @(negedge clk_l);
        chk("basic_ready", cmd_ready, 1);
        next();
        cmd_valid = 1'b0;
        @(negedge clk_l);
        chk("basic_en", inst_en, 30'h5);
        chk("basic_slice0", inst_data[0 +: W], 14'h1A5);
        chk("basic_slice2", inst_data[2*W +: W], 14'h1A5);
        chk("basic_cnt", issued_cnt, 1);
        for (k = 1; k <= 20; k++) begin
            next();
            @(negedge clk_l);
            if (k == 1) chk("basic_busy", row_busy, 30'h5);
            if (err_timeout) break;
        end
        chk("basic_timeout_cycle", k, TO);
        chk("basic_busy_after_to", row_busy, 0);
        next();
        // overlap stall on row 2, row 0 slips through
        status_sblk = 30'h4; cmd_valid = 1'b1; cmd_row_mask = 30'h4;
        @(negedge clk_l);
        chk("stall_ready", cmd_ready, 0);
        next();
        @(negedge clk_l);
        chk("stall_ready2", cmd_ready, 0);
        next();
        cmd_row_mask = 30'h1;
        @(negedge clk_l);
        chk("other_row_ready", cmd_ready, 1);
        next();
        cmd_row_mask = 30'h4;
        @(negedge clk_l);
        chk("other_row_en", inst_en, 30'h1);
        next();
        @(negedge clk_l);
        chk("still_stalled", cmd_ready, 0);
        next();
        status_sblk = '0;
        @(negedge clk_l);
        chk("release_ready", cmd_ready, 1);
        next();
        cmd_valid = 1'b0;
        @(negedge clk_l);
        chk("release_en", inst_en, 30'h4);
        chk("release_cnt", issued_cnt, 3);
        next();
        status_sblk = 30'h4;
        next();
        next();
        status_sblk = '0;
        wait_idle("idle_before_barrier");
        // barrier held by row 7
        status_sblk = 30'h80; cmd_valid = 1'b1; cmd_barrier = 1'b1; cmd_row_mask = 30'h1;
        repeat (3) begin
            @(negedge clk_l);
            chk("barrier_hold", cmd_ready, 0);
            next();
        end
        status_sblk = '0;
        @(negedge clk_l);
        chk("barrier_ready", cmd_ready, 1);
        next();
        cmd_valid = 1'b0; cmd_barrier = 1'b0;
        @(negedge clk_l);
        chk("barrier_en", inst_en, 30'h1);
        chk("barrier_cnt", issued_cnt, 4);
        next();
        wait_idle("idle_before_drain");
        // drain raised during ISSUE; row 3 never starts and times out
        cmd_valid = 1'b1; cmd_row_mask = 30'h8;
        @(negedge clk_l);
        chk("drain_accept", cmd_ready, 1);
        next();
        drain_req = 1'b1; cmd_row_mask = 30'h10;
        @(negedge clk_l);
        chk("drain_en", inst_en, 30'h8);
        chk("drain_ready", cmd_ready, 0);
        next();
        for (k = 1; k <= 20; k++) begin
            @(negedge clk_l);
            if (k == 5) chk("drain_block", cmd_ready, 0);
            if (err_timeout) break;
            next();
        end
        chk("row3_timeout_cycle", k, TO);
        chk("row3_busy", row_busy[3], 0);
        chk("drain_idle", sched_idle, 1);
        next();
        // empty mask
        drain_req = 1'b0; cmd_row_mask = '0;
        @(negedge clk_l);
        chk("empty_ready", cmd_ready, 1);
        next();
        cmd_valid = 1'b0;
        @(negedge clk_l);
        chk("empty_err", err_empty, 1);
        chk("empty_en", inst_en, 0);
        chk("empty_cnt", issued_cnt, 5);
        next();
        // reset coinciding with a would-be accept
        cmd_valid = 1'b1; cmd_row_mask = 30'h3; rst = 1'b1;
        next();
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk_l);
        chk("abort_en", inst_en, 0);
        chk("abort_cnt", issued_cnt, 0);
        next();
        // randomized traffic; rows 20+ never report busy so they exercise timeouts
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < N; i++)
                status_sblk[i] = status_sblk[i] ? ($urandom_range(3) != 0)
                                                : (i < 20 && $urandom_range(15) == 0);
            cmd_valid    = $urandom_range(2) != 0;
            cmd_row_mask = ($urandom_range(9) == 0) ? '0 : N'($urandom & $urandom & $urandom);
            cmd_inst     = W'($urandom);
            cmd_barrier  = $urandom_range(7) == 0;
            drain_req    = $urandom_range(15) == 0;
            rst          = (n == 2000);
            next();
        end
        rst = 1'b0; cmd_valid = 1'b0;
        next();
        @(negedge clk_l);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
